// File: rtl/cpu_types_pkg.sv
// Shared CPU types: memory word, RAM status codes and arbiter states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    DREQ,
    IREQ,
    DDONE,
    IDONE
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Request-unit and RAM signals seen by the memory arbiter.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic      imemREN;
  word_t     imemaddr;
  logic      dmemREN;
  logic      dmemWEN;
  word_t     dmemaddr;
  word_t     dmemstore;
  logic      ihit;
  logic      dhit;
  word_t     imemload;
  word_t     dmemload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      err;

  // Arbiter view
  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ramload, ramstate,
    output ihit, dhit, imemload, dmemload,
    output ramREN, ramWEN, ramaddr, ramstore, err
  );

  // Request unit plus RAM view
  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ramload, ramstate,
    input  ihit, dhit, imemload, dmemload,
    input  ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data beats instruction, with timeout and sticky error.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter word_t       ERRWORD = 32'hBAD1BAD1
) (
  input logic             CLK,
  input logic             RST,
  memory_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  arb_state_t    state_q, state_d;
  word_t         addr_q, addr_d;
  word_t         store_q, store_d;
  logic          opw_q, opw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  word_t         iload_q, iload_d;
  word_t         dload_q, dload_d;
  logic          err_q, err_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic          ihit_q, ihit_d;
  logic          dhit_q, dhit_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    opw_d   = opw_q;
    cnt_d   = cnt_q;
    iload_d = iload_q;
    dload_d = dload_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.dmemREN || bus.dmemWEN) begin
          state_d = DREQ;
          addr_d  = bus.dmemaddr;
          store_d = bus.dmemstore;
          opw_d   = bus.dmemWEN;
          cnt_d   = '0;
        end else if (bus.imemREN) begin
          state_d = IREQ;
          addr_d  = bus.imemaddr;
          store_d = bus.dmemstore;
          opw_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      DREQ, IREQ: begin
        if (bus.ramstate == ACCESS) begin
          if (state_q == IREQ)  iload_d = bus.ramload;
          else if (!opw_q)      dload_d = bus.ramload;
          state_d = (state_q == IREQ) ? IDONE : DDONE;
        end else if (bus.ramstate == ERROR || cnt_q == TMAX) begin
          if (state_q == IREQ)  iload_d = ERRWORD;
          else if (!opw_q)      dload_d = ERRWORD;
          err_d   = 1'b1;
          state_d = (state_q == IREQ) ? IDONE : DDONE;
        end else begin
          // Only reached below TMAX, so the counter saturates rather than wraps
          cnt_d = cnt_q + CW'(1);
        end
      end
      DDONE, IDONE: state_d = IDLE;
      default:      state_d = IDLE;
    endcase

    // Enables and hits are registered from the next state so they are glitch-free
    ren_d  = (state_d == IREQ) || ((state_d == DREQ) && !opw_d);
    wen_d  = (state_d == DREQ) && opw_d;
    ihit_d = (state_d == IDONE);
    dhit_d = (state_d == DDONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      opw_q   <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      err_q   <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      opw_q   <= opw_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      err_q   <= err_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.imemload = iload_q;
  assign bus.dmemload = dload_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter against a transaction-level latency/result model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned TO = 4;
  localparam word_t       EW = 32'hBAD1BAD1;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  memory_arbiter_if bus();

  memory_arbiter #(.TIMEOUT(TO), .ERRWORD(EW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // RAM contents as written by the DUT, and as the model expects them
  word_t ram_mem[word_t];
  word_t ref_mem[word_t];
  int    ram_cnt  = 0;
  int    ram_lat  = 1;
  int    ram_mode = 0;   // 0: ACCESS at ram_lat, 1: ERROR at ram_lat, 2: BUSY forever

  word_t exp_iload = '0;
  word_t exp_dload = '0;
  logic  exp_err   = 1'b0;

  function word_t seed_word(input word_t a);
    return a ^ 32'hC0DE0000;
  endfunction

  function word_t ram_rd(input word_t a);
    return ram_mem.exists(a) ? ram_mem[a] : seed_word(a);
  endfunction

  function word_t ref_rd(input word_t a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // RAM model: counts cycles of asserted enables and answers on the scheduled one
  initial begin
    bus.ramstate = FREE;
    bus.ramload  = '0;
    forever begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN) begin
        ram_cnt++;
        if (ram_mode != 2 && ram_cnt == ram_lat) begin
          bus.ramstate = (ram_mode == 1) ? ERROR : ACCESS;
          if (ram_mode == 0 && bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
          bus.ramload = (ram_mode == 0) ? ram_rd(bus.ramaddr) : $urandom();
        end else begin
          bus.ramstate = BUSY;
          bus.ramload  = $urandom();
        end
      end else begin
        ram_cnt      = 0;
        bus.ramstate = ($urandom_range(0, 1) == 0) ? FREE : BUSY;
        bus.ramload  = $urandom();
      end
    end
  end

  // Caller has driven the request in an IDLE cycle; runs it through to the following IDLE cycle.
  task automatic run_txn(input bit is_d, input bit wr, input word_t addr, input word_t store,
                         input int lat, input int mode, input string name);
    int       n_req;
    bit       fail;
    word_t    want;
    logic [3:0] exp_sig;
    n_req    = (mode == 2 || lat > int'(TO) + 1) ? int'(TO) + 1 : lat;
    fail     = (mode != 0) || (lat > int'(TO) + 1);
    ram_lat  = lat;
    ram_mode = mode;
    tick();
    if (is_d) begin
      bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
      bus.dmemaddr = $urandom(); bus.dmemstore = $urandom();
    end else begin
      bus.imemREN = 1'b0; bus.imemaddr = $urandom();
    end
    exp_sig = {(!is_d || !wr), (is_d && wr), 2'b00};
    for (int c = 1; c <= n_req; c++) begin
      checks++;
      if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit} !== exp_sig || bus.ramaddr !== addr ||
          (wr && bus.ramstore !== store)) begin
        errors++;
        $display("FAIL %s req cycle %0d: ren/wen/ihit/dhit=%b addr=%h store=%h, want %b addr=%h store=%h",
                 name, c, {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}, bus.ramaddr, bus.ramstore,
                 exp_sig, addr, store);
      end
      tick();
    end
    if (wr) begin
      if (!fail) ref_mem[addr] = store;
    end else begin
      want = fail ? EW : ref_rd(addr);
      if (is_d) exp_dload = want;
      else      exp_iload = want;
    end
    if (fail) exp_err = 1'b1;
    checks++;
    if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit} !== {2'b00, !is_d, is_d} ||
        bus.imemload !== exp_iload || bus.dmemload !== exp_dload || bus.err !== exp_err) begin
      errors++;
      $display("FAIL %s hit cycle %0d: ren/wen/ihit/dhit=%b iload=%h dload=%h err=%b, want %b iload=%h dload=%h err=%b",
               name, n_req + 1, {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}, bus.imemload,
               bus.dmemload, bus.err, {2'b00, !is_d, is_d}, exp_iload, exp_dload, exp_err);
    end
    tick();
    checks++;
    if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit} !== 4'b0000 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL %s gap: ren/wen/ihit/dhit=%b state=%0d, want 0000 state=IDLE",
               name, {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}, dut.state_q);
    end
  endtask

  task automatic test_reset();
    bus.imemREN = 1'b0; bus.imemaddr = '0;
    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.dmemaddr = '0; bus.dmemstore = '0;
    RST = 1'b1;
    #3;
    checks++;
    if ({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.err} !== 5'b0 || bus.imemload !== '0 ||
        bus.dmemload !== '0 || bus.ramaddr !== '0 || bus.ramstore !== '0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_state: hit/en/err=%b iload=%h dload=%h addr=%h store=%h state=%0d, want all 0 IDLE",
               {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.err}, bus.imemload, bus.dmemload,
               bus.ramaddr, bus.ramstore, dut.state_q);
    end
    tick(); tick();
    RST = 1'b0;
    exp_iload = '0; exp_dload = '0; exp_err = 1'b0;
    tick();
  endtask

  task automatic test_ifetch();
    ram_mem[32'h40] = 32'h8C220004;
    ref_mem[32'h40] = 32'h8C220004;
    bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
    run_txn(1'b0, 1'b0, 32'h40, '0, 3, 0, "ifetch");
    checks++;
    if (bus.imemload !== 32'h8C220004) begin
      errors++;
      $display("FAIL ifetch_load: imemload=%h, want 8c220004", bus.imemload);
    end
  endtask

  task automatic test_priority();
    bus.dmemWEN = 1'b1; bus.dmemaddr = 32'h100; bus.dmemstore = 32'hDEADBEEF;
    bus.imemREN = 1'b1; bus.imemaddr = 32'h200;
    run_txn(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1, 0, "prio_data");
    run_txn(1'b0, 1'b0, 32'h200, '0, 1, 0, "prio_instr");
  endtask

  task automatic test_rw_both();
    bus.dmemREN = 1'b1; bus.dmemWEN = 1'b1; bus.dmemaddr = 32'h104; bus.dmemstore = 32'h12345678;
    run_txn(1'b1, 1'b1, 32'h104, 32'h12345678, 2, 0, "rw_both");
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h104;
    run_txn(1'b1, 1'b0, 32'h104, '0, 1, 0, "rw_readback");
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100;
    run_txn(1'b1, 1'b0, 32'h100, '0, 2, 0, "prio_readback");
  endtask

  task automatic test_timeout();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_before_timeout: err=%b, want 0", bus.err);
    end
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h400;
    run_txn(1'b1, 1'b0, 32'h400, '0, 1, 2, "timeout");
    checks++;
    if (bus.dmemload !== 32'hBAD1BAD1 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result: dmemload=%h err=%b, want bad1bad1 1", bus.dmemload, bus.err);
    end
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h104;
    run_txn(1'b1, 1'b0, 32'h104, '0, 1, 0, "sticky_err_d");
    bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
    run_txn(1'b0, 1'b0, 32'h40, '0, 2, 0, "sticky_err_i");
  endtask

  task automatic test_error();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h44;
    run_txn(1'b0, 1'b0, 32'h44, '0, 1, 1, "ram_error");
    checks++;
    if (bus.imemload !== 32'hBAD1BAD1 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL ram_error_result: imemload=%h err=%b, want bad1bad1 1", bus.imemload, bus.err);
    end
  endtask

  task automatic test_random();
    int    kind, lat, mode;
    word_t a, ia, s;
    bit    wr;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      lat  = int'($urandom_range(1, 7));
      mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
      a    = 32'h300 + 32'($urandom_range(0, 7)) * 4;
      ia   = 32'h300 + 32'($urandom_range(0, 7)) * 4;
      s    = $urandom();
      if (kind == 0) begin
        bus.imemREN = 1'b1; bus.imemaddr = a;
        run_txn(1'b0, 1'b0, a, s, lat, mode, "rand_i");
      end else begin
        wr = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
        bus.dmemWEN = wr;
        bus.dmemREN = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.dmemaddr = a; bus.dmemstore = s;
        if (kind == 3) begin
          bus.imemREN = 1'b1; bus.imemaddr = ia;
        end
        run_txn(1'b1, wr, a, s, lat, mode, "rand_d");
        if (kind == 3) run_txn(1'b0, 1'b0, ia, '0, int'($urandom_range(1, 7)), 0, "rand_dual_i");
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h500;
    ram_mode = 2;
    tick();
    bus.dmemREN = 1'b0;
    checks++;
    if ({bus.ramREN, bus.err} !== {1'b1, exp_err}) begin
      errors++;
      $display("FAIL mid_req: ramREN/err=%b, want %b", {bus.ramREN, bus.err}, {1'b1, exp_err});
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({bus.ramREN, bus.ramWEN, bus.err, bus.dhit, bus.ihit} !== 5'b0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL async_reset: ren/wen/err/dhit/ihit=%b state=%0d, want 00000 IDLE",
               {bus.ramREN, bus.ramWEN, bus.err, bus.dhit, bus.ihit}, dut.state_q);
    end
    tick();
    RST = 1'b0;
    exp_iload = '0; exp_dload = '0; exp_err = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus.ramREN, bus.ramWEN, bus.dhit, bus.ihit} !== 4'b0 || dut.state_q !== IDLE) begin
        errors++;
        $display("FAIL post_reset_idle %0d: ren/wen/dhit/ihit=%b state=%0d, want 0000 IDLE",
                 c, {bus.ramREN, bus.ramWEN, bus.dhit, bus.ihit}, dut.state_q);
      end
    end
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h104;
    run_txn(1'b1, 1'b0, 32'h104, '0, 2, 0, "after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ifetch();
    test_priority();
    test_rw_both();
    test_timeout();
    test_error();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Responder side of the request-unit handshake: consumes imemREN, dmemREN and dmemWEN, and returns single-cycle ihit/dhit pulses with load data.
- Arbitrates instruction and data traffic onto one single-ported RAM. Data has priority over instruction.
- Sits between the datapath's request unit and the RAM model.
- Provides a timeout and error path so that the pipeline can never deadlock on a hung RAM.

Parameters:
TIMEOUT, 255, max cycles spent in a request state waiting for ramstate==ACCESS before forced completion
ERRWORD, 32'hBAD1BAD1, load value returned on error or timeout

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  reset, asynchronous, active-high
imemREN  input  1  instruction read request
imemaddr  input  32  instruction word address
dmemREN  input  1  data read request
dmemWEN  input  1  data write request
dmemaddr  input  32  data address
dmemstore  input  32  data write value
ihit  output  1  instruction access complete, one-cycle pulse
dhit  output  1  data access complete, one-cycle pulse
imemload  output  32  instruction read data, held until next instruction completion
dmemload  output  32  data read data, held until next data read completion
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
err  output  1  sticky error flag

Behaviour:
- Reset is asynchronous and active-high. All outputs go to 0, the state goes to IDLE, and the latched address/store/op and timeout counter clear. RAM enables drop in the same instant that RST rises, including mid-transaction.
- States: IDLE, DREQ, IREQ, DDONE, IDONE.
- IDLE:
  - dmemREN|dmemWEN -> DREQ.
  - else imemREN -> IREQ.
  - else stay.
  - On any transition, latch the address, dmemstore and op (write if dmemWEN; dmemWEN wins when dmemREN is also high), and clear the counter.
- DREQ/IREQ:
  - Drive ramaddr/ramstore from the latches. Drive ramWEN=op_write or ramREN=!op_write; IREQ always reads. Enables are registered and decoded from state only.
  - ramstate==ACCESS -> capture ramload (reads only) into dmemload/imemload, go to DDONE/IDONE.
  - ramstate==ERROR, or counter==TIMEOUT -> load ERRWORD into the target load register (reads only), set err, go to DONE.
  - Otherwise the counter increments. BUSY and FREE both wait.
- DDONE/IDONE:
  - dhit/ihit=1 for exactly this cycle. RAM enables are 0.
  - Always -> IDLE. Mandatory one-cycle gap; no back-to-back issue.
- Latency: a request sampled in IDLE at cycle 0 has enables high from cycle 1. If ACCESS arrives at cycle k≥1, the hit is at cycle k+1. Minimum request-to-hit is 2 cycles.
- A request deasserted during REQ still completes and still pulses its hit; the requester ignores it.
- A request still high in IDLE after its hit is serviced again. The request unit must drop REN on the hit.
- Input changes during REQ/DONE are ignored; latched values only.
- Simultaneous instruction and data requests in IDLE: data goes first. The instruction request waits and is taken in the IDLE after DDONE if still asserted.
- err is cleared only by RST.
- ihit and dhit are never high together.
- Load registers update only on the completing read of their own type.
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.

Decomposition:
- cpu_types_pkg gains ramstate_t (FREE, BUSY, ACCESS, ERROR) and reuses word_t.
- arb_state_t (IDLE, DREQ, IREQ, DDONE, IDONE) also goes in the package so benches can probe the state.
- Single module; no sub-module. The counter is an inline always_ff.

Test Plan:
1. Instruction read, imemaddr=0x40, RAM returns ACCESS on the 3rd REQ cycle with ramload=0x8C220004 -> ramREN for 3 cycles, ihit high 4 cycles after the request for 1 cycle, imemload=0x8C220004, dhit=0.
2. Simultaneous dmemWEN(addr 0x100, store 0xDEADBEEF) and imemREN, 1-cycle RAM -> ramWEN first with ramaddr=0x100/ramstore=0xDEADBEEF, dhit at cycle 2, IDLE at cycle 3, ramREN for the instruction from cycle 4, ihit at cycle 5.
3. dmemREN and dmemWEN both high -> write performed, ramREN=0 throughout, dmemload unchanged.
4. ramstate held BUSY, TIMEOUT=4 -> dhit at request+6, dmemload=0xBAD1BAD1, err=1 and stays 1 through later good transactions.
5. ramstate=ERROR on first REQ cycle of an instruction read -> ihit next cycle, imemload=0xBAD1BAD1, err=1.
6. RST raised while in DREQ -> ramREN/ramWEN/err/dhit are 0 immediately (asynchronous, no clock edge needed). After release with dmemREN low, the block stays IDLE with no hit.
